// File: rtl/ahb_lite_interconnect_pkg.sv
// Shared AHB-Lite constants, default-slave state encoding and small helpers.
// No logic latency (types and functions only).
// No backpressure (package has no handshakes).
package ahb_lite_interconnect_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int ERR_COUNT_W = 8;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    typedef struct packed {
        logic hready;
        logic hresp;
    } ds_resp_t;

    // NONSEQ and SEQ carry data; IDLE and BUSY never do.
    function automatic logic htrans_active(input logic [1:0] htrans);
        logic act;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
            default:                   act = 1'b0;
        endcase
        return act;
    endfunction

    function automatic logic [ERR_COUNT_W-1:0] sat_inc(input logic [ERR_COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ahb_lite_interconnect_default_slave.sv
// Default slave for unmapped addresses: two-cycle ERROR FSM plus error log.
// Latency: unmapped active transfers take two data-phase cycles, otherwise zero.
// Backpressure: inserts one wait state (ERR1); only samples when global HREADY is high.
module ahb_default_slave
    import ahb_lite_interconnect_pkg::*;
#(
    parameter int PA_BITS         = 34,
    parameter bit ERR_ON_UNMAPPED = 1'b1
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   hready,
    input  logic                   unmapped_act,
    input  logic [PA_BITS-1:0]     haddr,
    input  logic                   hwrite,
    input  logic                   err_clr,
    output ds_resp_t               ds_resp,
    output logic                   err_valid,
    output logic [PA_BITS-1:0]     err_addr,
    output logic                   err_write,
    output logic [ERR_COUNT_W-1:0] err_count
);

    ds_state_e                state_q, state_d;
    logic                     err_valid_q, err_valid_d;
    logic [PA_BITS-1:0]       err_addr_q, err_addr_d;
    logic                     err_write_q, err_write_d;
    logic [ERR_COUNT_W-1:0]   err_count_q, err_count_d;
    logic                     log_evt;

    assign log_evt = hready & unmapped_act;

    // Outputs depend on state only, keeping the global HREADY path loop-free.
    always_comb begin
        ds_resp = '{hready: 1'b1, hresp: HRESP_OKAY};
        case (state_q)
            DS_ERR1: ds_resp = '{hready: 1'b0, hresp: HRESP_ERROR};
            DS_ERR2: ds_resp = '{hready: 1'b1, hresp: HRESP_ERROR};
            default: ds_resp = '{hready: 1'b1, hresp: HRESP_OKAY};
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DS_IDLE: if (log_evt && ERR_ON_UNMAPPED) state_d = DS_ERR1;
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: state_d = (log_evt && ERR_ON_UNMAPPED) ? DS_ERR1 : DS_IDLE;
            default: state_d = DS_IDLE;
        endcase
    end

    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        err_write_d = err_write_q;
        err_count_d = err_count_q;
        if (log_evt) begin
            // A new error wins over a simultaneous clear.
            if (!err_valid_q || err_clr) begin
                err_addr_d  = haddr;
                err_write_d = hwrite;
            end
            err_valid_d = 1'b1;
            err_count_d = sat_inc(err_clr ? '0 : err_count_q);
        end else if (err_clr) begin
            err_valid_d = 1'b0;
            err_count_d = '0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= DS_IDLE;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_write_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            err_write_q <= err_write_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;
    assign err_write = err_write_q;
    assign err_count = err_count_q;

endmodule

// File: rtl/ahb_lite_interconnect.sv
// AHB-Lite single-manager interconnect: address decode, data-phase select, response mux.
// Latency: zero added cycles for mapped slaves; unmapped active transfers take two cycles.
// Backpressure: selected slave's HREADYOUT (or default slave) stalls the whole bus via HREADY.
module ahb_lite_interconnect
    import ahb_lite_interconnect_pkg::*;
#(
    parameter int                         NSLAVES         = 8,
    parameter int                         PA_BITS         = 34,
    parameter int                         DW              = 64,
    parameter logic [NSLAVES*PA_BITS-1:0] SLV_BASE        = '0,
    parameter logic [NSLAVES*PA_BITS-1:0] SLV_MASK        = '0,
    parameter bit                         ERR_ON_UNMAPPED = 1'b1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [PA_BITS-1:0]    HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    output logic [NSLAVES-1:0]    HSELS,
    input  logic [NSLAVES-1:0]    HREADYOUTS,
    input  logic [NSLAVES-1:0]    HRESPS,
    input  logic [NSLAVES*DW-1:0] HRDATAS,
    output logic [DW-1:0]         HRDATA,
    output logic                  HREADY,
    output logic                  HRESP,
    input  logic                  ErrClr,
    output logic                  ErrValid,
    output logic [PA_BITS-1:0]    ErrAddr,
    output logic                  ErrWrite,
    output logic [7:0]            ErrCount
);

    localparam logic [NSLAVES:0] DSEL_DEFAULT = {1'b1, {NSLAVES{1'b0}}};

    logic [NSLAVES-1:0] hit;
    logic [NSLAVES-1:0] hsel;
    logic               unmapped;
    logic               unmapped_act;
    logic [NSLAVES:0]   dsel_q, dsel_d;
    logic [DW-1:0]      hrdata;
    logic               hready;
    logic               hresp;
    ds_resp_t           ds_resp;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            hit[i] = ((HADDR & SLV_MASK[i*PA_BITS +: PA_BITS]) == SLV_BASE[i*PA_BITS +: PA_BITS]);
        end
    end

    // Lowest index wins on overlapping regions so the select stays one-hot.
    always_comb begin
        logic taken;
        hsel  = '0;
        taken = 1'b0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (hit[i] && !taken) begin
                hsel[i] = 1'b1;
                taken   = 1'b1;
            end
        end
    end

    assign unmapped     = ~|hsel;
    assign unmapped_act = unmapped & htrans_active(HTRANS);
    assign HSELS        = hsel;

    always_comb begin
        dsel_d = dsel_q;
        if (hready) begin
            dsel_d = {unmapped, hsel};
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel_q <= DSEL_DEFAULT;
        end else begin
            dsel_q <= dsel_d;
        end
    end

    // dsel_q is one-hot, so at most one slave overrides the default-slave response.
    always_comb begin
        hrdata = '0;
        hready = ds_resp.hready;
        hresp  = ds_resp.hresp;
        for (int k = 0; k < NSLAVES; k++) begin
            if (dsel_q[k]) begin
                hrdata = HRDATAS[k*DW +: DW];
                hready = HREADYOUTS[k];
                hresp  = HRESPS[k];
            end
        end
    end

    assign HRDATA = hrdata;
    assign HREADY = hready;
    assign HRESP  = hresp;

    ahb_default_slave #(
        .PA_BITS         (PA_BITS),
        .ERR_ON_UNMAPPED (ERR_ON_UNMAPPED)
    ) u_default_slave (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .hready       (hready),
        .unmapped_act (unmapped_act),
        .haddr        (HADDR),
        .hwrite       (HWRITE),
        .err_clr      (ErrClr),
        .ds_resp      (ds_resp),
        .err_valid    (ErrValid),
        .err_addr     (ErrAddr),
        .err_write    (ErrWrite),
        .err_count    (ErrCount)
    );

endmodule
